ps2_rx_frame: RTL and testbench
===============================

Name: ps2_rx_frame

Overview:
- Upstream receiver stage for the Proyect top level.
- Synchronizes and deglitches the raw ps2clk/ps2data lines from the keyboard.
- Deserializes each 11-bit PS/2 device-to-host frame and hands one validated scan-code byte per frame, with a single-cycle strobe, to the downstream command FSM.
- Reports parity and framing errors; recovers from truncated frames with a watchdog.

Parameters:
- FILTER_LEN, 8: consecutive CLK_G cycles the synchronized ps2clk must hold a new level before the filtered clock changes.
- TIMEOUT_CYC, 20000: CLK_G cycles allowed between falling edges inside a frame (200 us at 100 MHz) before the frame is abandoned.

Ports:
- CLK_G  input  1  system clock, 100 MHz, rising edge.
- reset_G  input  1  synchronous, active-high reset.
- ps2clk  input  1  raw PS/2 clock line, asynchronous.
- ps2data  input  1  raw PS/2 data line, asynchronous.
- Rx_en  input  1  receive enable; a new frame is only accepted while high.
- dout  output  8  last good scan code; held until the next good frame.
- rx_done_tick  output  1  one-cycle strobe when dout is updated.
- parity_err  output  1  one-cycle strobe: frame had bad odd parity.
- frame_err  output  1  one-cycle strobe: bad start bit, bad stop bit, or timeout.
- busy  output  1  high while a frame is being received.

Behaviour:
- Reset: while reset_G=1 at a CLK_G edge, the block is cleared:
  - outputs: dout=8'h00, rx_done_tick=0, parity_err=0, frame_err=0, busy=0.
  - state: FSM=IDLE, bit counter=0, shift register=0.
  - sync flops and filtered clock preset to 1 (idle bus).
  - Reset mid-frame discards the partial frame; no strobe is emitted.
- Input conditioning:
  - Two-flop synchronizer on each of ps2clk and ps2data.
  - Filter: a saturating counter tracks how long the synchronized clock has differed from the filtered clock. The filtered clock takes the new level after FILTER_LEN consecutive differing cycles; any agreeing cycle clears the counter.
  - fall = filtered clock 1->0, registered for one cycle.
  - Data is sampled from the synchronized ps2data in the fall cycle.
- FSM states: IDLE, RECV, CHECK.
  - IDLE:
    - On fall with Rx_en=1: if sampled data=0 (start bit), go to RECV with bit count=0. If sampled data=1, pulse frame_err and stay in IDLE.
    - On fall with Rx_en=0: ignored, no error.
  - RECV:
    - Each fall shifts the sample into a 10-bit register, LSB-first order (8 data bits, parity, stop).
    - After the 10th bit, go to CHECK.
    - Rx_en dropping mid-frame does not abort the frame.
  - CHECK (exactly one cycle, then IDLE):
    - Stop bit = 0: pulse frame_err only; dout unchanged.
    - Else if XOR of data+parity != 1: pulse parity_err only; dout unchanged.
    - Else: load dout and pulse rx_done_tick.
    - At most one of the three strobes fires per frame.
- Timeout:
  - In RECV, a cycle counter clears on every fall.
  - When it reaches TIMEOUT_CYC: return to IDLE, pulse frame_err, discard partial data.
- busy = 1 in RECV and CHECK.
- Latency: rx_done_tick is asserted in the cycle after the fall cycle of the stop bit. That is FILTER_LEN+4 CLK_G cycles (±1) after the raw ps2clk stop-bit falling edge.
- Glitch immunity: ps2clk pulses shorter than FILTER_LEN cycles never produce a fall.
- Back-to-back frames: a start-bit fall arriving one cycle after CHECK is accepted.
- Widths:
  - Bit counter: 4 bits.
  - Timeout counter: $clog2(TIMEOUT_CYC+1) bits, saturating.
  - Filter counter: $clog2(FILTER_LEN+1) bits.

Test Plan:
- Nominal byte: reset 100 ns, Rx_en=1, send frame for 0x1C at 12.5 kHz. Bits LSB-first: start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1. Expect: rx_done_tick exactly one cycle, dout=8'h1C, no error strobes, busy low afterwards.
- Break sequence: send 0xF0 (parity 1) then 0x1C back-to-back. Expect: two rx_done_ticks, dout=8'hF0 then 8'h1C.
- Parity error: send 0x1C with parity=1. Expect: parity_err one cycle, no rx_done_tick, dout keeps its previous value.
- Framing and timeout:
  - Send 0x1C with stop=0. Expect: frame_err, dout unchanged.
  - Separately, stop ps2clk after 5 bits. Expect: frame_err exactly TIMEOUT_CYC cycles after the last fall; the next full frame of 0x29 is received correctly.
- Gating and glitches:
  - Send 0x1C with Rx_en=0. Expect: no strobes, busy stays 0.
  - Inject 3-cycle ps2clk low glitches between bits of a valid frame. Expect: the byte is still received correctly.
- Reset mid-frame: assert reset_G for one cycle after bit 4 of 0x1C, then send a fresh 0x32 frame. Expect: all outputs at reset values, no strobe for the aborted frame, then rx_done_tick with dout=8'h32.

Source files
------------

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: synchronizes and deglitches ps2clk/ps2data,
// deserializes 11-bit frames and strobes out one checked scan code per frame.
module ps2_rx_frame #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       CLK_G,
  input  logic       reset_G,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic       Rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt, clk_filt_d, fall;
  logic [FW-1:0] fcnt;

  logic [1:0]    state;
  logic [3:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic [9:0]    sh;
  logic [9:0]    sh_nxt;

  // Bit 1 of each sync pair is the synchronized level.
  always_ff @(posedge CLK_G) begin
    if (reset_G) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      fcnt       <= '0;
      fall       <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2clk};
      dat_sync   <= {dat_sync[0], ps2data};
      clk_filt_d <= clk_filt;
      fall       <= clk_filt_d & ~clk_filt;
      if (clk_sync[1] == clk_filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        fcnt     <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  // Frame is shifted in LSB first: sh[7:0] data, sh[8] parity, sh[9] stop.
  assign sh_nxt = {dat_sync[1], sh[9:1]};

  // Frame checks are resolved on the stop-bit fall so the strobe and the new
  // dout appear together in the single CHECK cycle.
  always_ff @(posedge CLK_G) begin
    if (reset_G) begin
      state        <= IDLE;
      bcnt         <= '0;
      tcnt         <= '0;
      sh           <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (fall && Rx_en) begin
            if (!dat_sync[1]) begin
              state <= RECV;
              bcnt  <= '0;
              tcnt  <= TW'(1);
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        RECV: begin
          if (fall) begin
            sh   <= sh_nxt;
            tcnt <= TW'(1);
            bcnt <= bcnt + 4'd1;
            if (bcnt == 4'd9) begin
              state <= CHECK;
              if (!sh_nxt[9])
                frame_err <= 1'b1;
              else if ((^sh_nxt[8:0]) != 1'b1)
                parity_err <= 1'b1;
              else begin
                dout         <= sh_nxt[7:0];
                rx_done_tick <= 1'b1;
              end
            end
          // tcnt counts the fall cycle as 1, so this fires TIMEOUT_CYC cycles after it
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            sh        <= '0;
            bcnt      <= '0;
          end else if (tcnt != TW'(TIMEOUT_CYC)) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        CHECK: begin
          state <= IDLE;
          bcnt  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RECV) || (state == CHECK);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: table of frames plus hand sequences, scoreboarded
// strobes checked for kind, dout and latency from the raw ps2clk fall.
module tb_ps2_rx_frame;

  localparam int F = 8;
  localparam int T = 200;
  localparam int H = 20;
  localparam int K_NONE = 0, K_DONE = 1, K_PAR = 2, K_FRM = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick, parity_err, frame_err, busy;

  ps2_rx_frame #(.FILTER_LEN(F), .TIMEOUT_CYC(T)) dut (
    .CLK_G(clk), .reset_G(rst), .ps2clk(ps2clk), .ps2data(ps2data), .Rx_en(rx_en),
    .dout(dout), .rx_done_tick(rx_done_tick), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    bit         en;
    bit         glitch;
    bit         b2b;
    int         kind;
    logic [7:0] exp_dout;
  } vec_t;

  typedef struct {
    int         kind;
    logic [7:0] dout;
    int         lat;
  } exp_t;

  exp_t  q[$];
  exp_t  e;
  vec_t  vecs[11];
  int    checks = 0, errors = 0;
  int    cyc = 0, last_fall_cyc = 0;
  bit    busy_seen = 1'b0;
  logic [2:0] s, s_prev = 3'b000;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [2:0] kind_bits(input int k);
    case (k)
      K_DONE:  return 3'b001;
      K_PAR:   return 3'b010;
      K_FRM:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Scoreboard monitor: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    s = {frame_err, parity_err, rx_done_tick};
    if (s_prev != 3'b000) chk("strobe_one_cycle", int'(s), 0);
    if (s != 3'b000) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", int'(s), 0);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", int'(s), int'(kind_bits(e.kind)));
        chk("dout_at_strobe", int'(dout), int'(e.dout));
        chk("strobe_latency", cyc - last_fall_cyc, e.lat);
      end
    end
    s_prev = s;
    if (busy) busy_seen = 1'b1;
  end

  task automatic expect_ev(input int kind, input logic [7:0] d, input int lat);
    exp_t x;
    x.kind = kind; x.dout = d; x.lat = lat;
    q.push_back(x);
  endtask

  task automatic ps2_bit(input logic b, input bit g);
    ps2data = b;
    if (g) begin
      repeat (6) @(negedge clk);
      ps2clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2clk = 1'b1;
      repeat (H - 9) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    last_fall_cyc = cyc;
    ps2clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input bit g, input int nbits);
    logic [10:0] f;
    logic par;
    par = (~^d) ^ bad_par;
    f = {~bad_stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], g);
    ps2data = 1'b1;
  endtask

  task automatic settle(input string tag, input logic [7:0] d);
    repeat (30) @(negedge clk);
    chk({tag, "_queue_drained"}, q.size(), 0);
    chk({tag, "_busy_idle"}, int'(busy), 0);
    chk({tag, "_dout"}, int'(dout), int'(d));
  endtask

  initial begin
    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, K_DONE, 8'h1C};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, K_DONE, 8'hF0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, K_DONE, 8'h1C};
    vecs[3]  = '{8'h1C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, K_PAR,  8'h1C};
    vecs[4]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, K_FRM,  8'h1C};
    vecs[5]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_NONE, 8'h1C};
    vecs[6]  = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, K_DONE, 8'h29};
    vecs[7]  = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, K_DONE, 8'hA5};
    vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, K_DONE, 8'h00};
    vecs[9]  = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, K_DONE, 8'hFF};
    vecs[10] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, K_PAR,  8'hFF};

    rst = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_dout", int'(dout), 0);
    chk("reset_done", int'(rx_done_tick), 0);
    chk("reset_parity_err", int'(parity_err), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_busy", int'(busy), 0);

    for (int i = 0; i < 11; i++) begin
      rx_en = vecs[i].en;
      busy_seen = 1'b0;
      if (vecs[i].kind != K_NONE) expect_ev(vecs[i].kind, vecs[i].exp_dout, F + 4);
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, vecs[i].glitch, 11);
      if (!vecs[i].b2b) begin
        settle($sformatf("vec%0d", i), vecs[i].exp_dout);
        if (!vecs[i].en) chk("gated_busy_never_set", int'(busy_seen), 0);
      end
      rx_en = 1'b1;
    end

    // Lone fall with data high in IDLE is a bad start bit.
    expect_ev(K_FRM, 8'hFF, F + 4);
    ps2_bit(1'b1, 1'b0);
    settle("bad_start", 8'hFF);

    // Truncated frame: five bits then silence.
    expect_ev(K_FRM, 8'hFF, F + 3 + T);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 5);
    repeat (T + 40) @(negedge clk);
    chk("timeout_queue_drained", q.size(), 0);
    chk("timeout_busy_idle", int'(busy), 0);
    expect_ev(K_DONE, 8'h29, F + 4);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 11);
    settle("after_timeout", 8'h29);

    // Reset in the middle of a frame, then a fresh frame.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_dout", int'(dout), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_strobes", int'({frame_err, parity_err, rx_done_tick}), 0);
    repeat (H) @(negedge clk);
    expect_ev(K_DONE, 8'h32, F + 4);
    send_frame(8'h32, 1'b0, 1'b0, 1'b0, 11);
    settle("after_midreset", 8'h32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
